// File: rtl/tdm_demux_1x4.sv
// 1-to-4 TDM demultiplexer: collects four qualified serial slots into a word,
// framed by a slot-0 sync marker, with resync and framing-error reporting.
module tdm_demux_1x4 #(
  parameter bit REQUIRE_SYNC = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       en,
  input  logic       sync,
  output logic [3:0] o,
  output logic       valid,
  output logic       err,
  output logic [1:0] slot
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] o_q, o_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic       locked;
  logic       resync;
  logic       missing_sync;
  logic       frame_start;

  assign locked       = (state_q == StLocked);
  // Sync in the middle of a frame restarts it from slot 0.
  assign resync       = en && locked && sync && (slot_q != 2'd0);
  assign missing_sync = en && locked && !sync && (slot_q == 2'd0) && REQUIRE_SYNC;
  assign frame_start  = en && !locked && sync;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHunt;
      slot_q   <= 2'd0;
      shadow_q <= 4'd0;
      o_q      <= 4'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      o_q      <= o_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHunt: begin
        if (frame_start) state_d = StLocked;
      end
      StLocked: begin
        if (missing_sync) state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase
  end

  // Slot counter, shadow word and output word.
  always_comb begin
    slot_d   = slot_q;
    shadow_d = shadow_q;
    o_d      = o_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (frame_start || resync) begin
      shadow_d[0] = din;
      slot_d      = 2'd1;
      err_d       = resync;
    end else if (missing_sync) begin
      slot_d = 2'd0;
      err_d  = 1'b1;
    end else if (en && locked) begin
      shadow_d[slot_q] = din;
      slot_d           = slot_q + 2'd1;
      if (slot_q == 2'd3) begin
        o_d     = {din, shadow_q[2:0]};
        valid_d = 1'b1;
      end
    end
  end

  assign o     = o_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign slot  = slot_q;

endmodule
